// File: rtl/llc_mem_responder_pkg.sv
// Shared line/request types and constants for the LLC memory responder.
package llc_mem_responder_pkg;

   localparam int LINE_ADDR_BITS = 28;
   localparam int BITS_PER_LINE  = 128;
   localparam int LAT_BITS       = 8;    // holds RD_LATENCY-1 for RD_LATENCY up to 255

   typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
   typedef logic [BITS_PER_LINE-1:0]  line_t;
   typedef logic [2:0]                hsize_t;
   typedef logic                      hprot_t;

endpackage

// File: rtl/llc_mem_array.sv
// Single-port line-wide synchronous RAM with a one-cycle registered read.
module llc_mem_array #(
   parameter int DEPTH_LOG2 = 10,
   parameter int WIDTH      = 128
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

   // NOTE: memories get no reset so they map onto BRAM/SRAM macros.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/llc_mem_responder.sv
// Memory-side responder: services one LLC line read/write at a time against a
// local array and returns read data after a fixed latency.
module llc_mem_responder #(
   parameter int LINE_ADDR_BITS = llc_mem_responder_pkg::LINE_ADDR_BITS,
   parameter int LINE_BITS      = llc_mem_responder_pkg::BITS_PER_LINE,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int RD_LATENCY     = 4,
   parameter int CNT_BITS       = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      llc_mem_req_valid,
   output logic                      llc_mem_req_ready,
   input  logic                      llc_mem_req_hwrite,
   input  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr,
   input  logic [LINE_BITS-1:0]      llc_mem_req_line,
   input  logic [2:0]                llc_mem_req_hsize,
   input  logic                      llc_mem_req_hprot,
   output logic                      llc_mem_rsp_valid,
   input  logic                      llc_mem_rsp_ready,
   output logic [LINE_BITS-1:0]      llc_mem_rsp_line,
   output logic [CNT_BITS-1:0]       rd_count,
   output logic [CNT_BITS-1:0]       wr_count
);
   import llc_mem_responder_pkg::*;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

   state_t                    state, state_nxt;
   logic [LAT_BITS-1:0]       cnt, cnt_nxt;
   logic [MEM_DEPTH_LOG2-1:0] req_idx, rd_idx, arr_addr;
   logic [LINE_BITS-1:0]      arr_rdata;
   logic                      arr_we, arr_re, rd_accept, wr_accept, rsp_load;
   logic                      unused_ok;

   // Size, protection and address bits above the array depth are don't-cares.
   assign unused_ok = ^{llc_mem_req_hsize, llc_mem_req_hprot,
                        llc_mem_req_addr[LINE_ADDR_BITS-1:MEM_DEPTH_LOG2]};

   assign req_idx           = llc_mem_req_addr[MEM_DEPTH_LOG2-1:0];
   assign arr_addr          = (state == IDLE) ? req_idx : rd_idx;
   assign llc_mem_req_ready = (state == IDLE);
   assign llc_mem_rsp_valid = (state == RESP);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      rd_accept = 1'b0;
      wr_accept = 1'b0;
      rsp_load  = 1'b0;
      case (state)
         IDLE: begin
            if (llc_mem_req_valid && llc_mem_req_hwrite) begin
               arr_we    = 1'b1;
               wr_accept = 1'b1;
            end else if (llc_mem_req_valid) begin
               rd_accept = 1'b1;
               cnt_nxt   = LAT_BITS'(RD_LATENCY - 1);
               state_nxt = RD_WAIT;
               arr_re    = (RD_LATENCY == 1);
            end
         end
         RD_WAIT: begin
            // Issue the array read one cycle ahead so data lands as cnt hits 0.
            arr_re = (cnt == LAT_BITS'(1));
            if (cnt == '0) begin
               rsp_load  = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - LAT_BITS'(1);
            end
         end
         RESP: begin
            if (llc_mem_rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         rd_idx           <= '0;
         llc_mem_rsp_line <= '0;
         rd_count         <= '0;
         wr_count         <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (rd_accept) rd_idx <= req_idx;
         if (rsp_load) llc_mem_rsp_line <= arr_rdata;
         if (rd_accept && rd_count != '1) rd_count <= rd_count + 1'b1;
         if (wr_accept && wr_count != '1) wr_count <= wr_count + 1'b1;
      end
   end

   llc_mem_array #(
      .DEPTH_LOG2(MEM_DEPTH_LOG2),
      .WIDTH     (LINE_BITS)
   ) u_array (
      .clk  (clk),
      .we   (arr_we),
      .re   (arr_re),
      .addr (arr_addr),
      .wdata(llc_mem_req_line),
      .rdata(arr_rdata)
   );

endmodule

// File: tb/tb_llc_mem_responder.sv
// Directed and randomized bench for llc_mem_responder against a line-array model.
module tb_llc_mem_responder;

   localparam int LAB  = 28;
   localparam int LB   = 128;
   localparam int DL2  = 10;
   localparam int LAT  = 4;
   localparam int CB   = 4;
   localparam int CMAX = 15;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid, req_ready, req_hwrite, req_hprot, rsp_valid, rsp_ready;
   logic [LAB-1:0] req_addr;
   logic [LB-1:0]  req_line, rsp_line;
   logic [2:0]     req_hsize;
   logic [CB-1:0]  rd_count, wr_count;

   logic [LB-1:0] model_mem [int];
   int            exp_rd, exp_wr;
   int            checks, failures;

   always #5 clk = ~clk;

   llc_mem_responder #(
      .LINE_ADDR_BITS(LAB), .LINE_BITS(LB), .MEM_DEPTH_LOG2(DL2),
      .RD_LATENCY(LAT), .CNT_BITS(CB)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .llc_mem_req_valid (req_valid),
      .llc_mem_req_ready (req_ready),
      .llc_mem_req_hwrite(req_hwrite),
      .llc_mem_req_addr  (req_addr),
      .llc_mem_req_line  (req_line),
      .llc_mem_req_hsize (req_hsize),
      .llc_mem_req_hprot (req_hprot),
      .llc_mem_rsp_valid (rsp_valid),
      .llc_mem_rsp_ready (rsp_ready),
      .llc_mem_rsp_line  (rsp_line),
      .rd_count          (rd_count),
      .wr_count          (wr_count)
   );

   task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [LAB-1:0] a);
      return int'(a) % (1 << DL2);
   endfunction

   function automatic logic [LB-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_write(input logic [LAB-1:0] addr, input logic [LB-1:0] line);
      @(negedge clk);
      check("wr_ready", LB'(req_ready), LB'(1));
      check("wr_count_pre", LB'(wr_count), LB'(exp_wr));
      req_valid  = 1'b1;
      req_hwrite = 1'b1;
      req_addr   = addr;
      req_line   = line;
      req_hsize  = 3'($urandom);
      req_hprot  = 1'($urandom);
      @(posedge clk);
      #1 req_valid = 1'b0;
      model_mem[idx_of(addr)] = line;
      if (exp_wr < CMAX) exp_wr++;
   endtask

   // hold = cycles rsp_ready stays low after rsp_valid; 0 = ready raised early.
   task automatic do_read(input logic [LAB-1:0] addr, input int hold);
      logic [LB-1:0] exp_line;
      exp_line = model_mem[idx_of(addr)];
      @(negedge clk);
      check("rd_ready", LB'(req_ready), LB'(1));
      req_valid  = 1'b1;
      req_hwrite = 1'b0;
      req_addr   = addr;
      req_line   = rand_line();
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_line = rand_line();
      if (exp_rd < CMAX) exp_rd++;
      if (hold == 0) rsp_ready = 1'b1;
      for (int j = 1; j <= LAT; j++) begin
         @(posedge clk);
         @(negedge clk);
         check("rsp_valid_timing", LB'(rsp_valid), LB'(j == LAT));
         check("req_ready_busy", LB'(req_ready), LB'(0));
      end
      check("rsp_line", rsp_line, exp_line);
      check("rd_count", LB'(rd_count), LB'(exp_rd));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", LB'(rsp_valid), LB'(1));
         check("hold_line", rsp_line, exp_line);
         check("hold_req_ready", LB'(req_ready), LB'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_hs_valid", LB'(rsp_valid), LB'(0));
      check("post_hs_ready", LB'(req_ready), LB'(1));
      rsp_ready = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_req_ready", LB'(req_ready), LB'(1));
      check("rst_rsp_valid", LB'(rsp_valid), LB'(0));
      check("rst_rsp_line", rsp_line, '0);
      check("rst_rd_count", LB'(rd_count), LB'(0));
      check("rst_wr_count", LB'(wr_count), LB'(0));
      @(negedge clk);
      rst = 1'b0;
      exp_rd = 0;
      exp_wr = 0;
   endtask

   initial begin
      logic [LAB-1:0] a;
      checks = 0; failures = 0; exp_rd = 0; exp_wr = 0;
      rst = 1'b1; req_valid = 1'b0; req_hwrite = 1'b0; req_addr = '0;
      req_line = '0; req_hsize = '0; req_hprot = 1'b0; rsp_ready = 1'b0;
      #12;
      check("init_req_ready", LB'(req_ready), LB'(1));
      check("init_rsp_valid", LB'(rsp_valid), LB'(0));
      check("init_rsp_line", rsp_line, '0);
      check("init_counts", LB'({rd_count, wr_count}), LB'(0));
      @(negedge clk);
      rst = 1'b0;

      // Basic write then read with exact latency.
      do_write(28'h005, {16{8'hA5}});
      do_read(28'h005, 0);
      check("basic_wr_count", LB'(wr_count), LB'(1));
      check("basic_rd_count", LB'(rd_count), LB'(1));

      // Read in the cycle right after a write to the same index.
      do_write(28'h003, {16{8'h11}});
      do_read(28'h003, 1);

      // Upper address bits alias onto the same line.
      do_write(28'h0000401, {16{8'hEF}} | {64{2'b10}} & {LB{1'b0}});
      do_read(28'h0000001, 2);

      // Back-pressure for 10 cycles.
      do_read(28'h005, 10);

      // Randomized mix of writes and reads over a small index pool.
      for (int n = 0; n < 60; n++) begin
         a = {LAB{1'b0}};
         a[LAB-1:DL2] = (LAB - DL2)'($urandom);
         a[DL2-1:0]   = DL2'($urandom_range(0, 15));
         if (model_mem.exists(idx_of(a)) && ($urandom_range(0, 1) == 1))
            do_read(a, $urandom_range(0, 3));
         else
            do_write(a, rand_line());
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      check("rand_rd_count", LB'(rd_count), LB'(exp_rd));
      check("rand_wr_count", LB'(wr_count), LB'(exp_wr));

      // Reset two cycles into RD_WAIT drops the read and keeps the array.
      @(negedge clk);
      req_valid = 1'b1; req_hwrite = 1'b0; req_addr = 28'h003;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      apply_reset();
      for (int i = 0; i < LAT + 3; i++) begin
         @(negedge clk);
         check("dropped_rsp_valid", LB'(rsp_valid), LB'(0));
      end
      do_read(28'h005, 0);

      // Counter saturation with back-to-back writes.
      apply_reset();
      for (int i = 0; i < 20; i++) do_write(28'(i), rand_line());
      @(negedge clk);
      check("sat_wr_count", LB'(wr_count), LB'(CMAX));
      check("sat_req_ready", LB'(req_ready), LB'(1));
      do_read(28'h007, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
